// File: rtl/ingress_frame_reader.sv
// ingress_frame_reader
//
// Pulls per-port frame metadata, issues the SRAM word reads for each frame
// and re-attaches the frame header to the returning read data.
//
// Issue side: a three-state FSM (IDLE / META_WAIT / ISSUE) selects a
// non-empty ingress port round-robin, pops one metadata entry, waits for it,
// pushes a header into a small in-flight header queue and streams
// ceil(len/16) read requests at {port, rd_ptr[port]}.
// Data side: every returned word is paired with the header at the queue head
// and registered onto the out_* strobes. The head pops on the frame's last
// word.
//
// Ports
//   clk_ram_ctl     SRAM controller clock, all logic on its rising edge
//   rst             asynchronous active-high reset
//   meta_empty      per-port metadata FIFO empty
//   meta_rd         one-hot metadata pop pulse
//   meta_rdata      per-port {vlan[11:0], len[10:0]}, flattened port-major
//   fabric_ready    downstream accepts a new frame start
//   ram_rd_en       SRAM read request
//   ram_rd_addr     {port, word pointer}
//   fec_rd_valid    decoded read data valid (request order, fixed latency)
//   fec_rd_data     decoded read data
//   out_valid/out_start/out_last/out_data/out_last_bytes   frame data strobes
//   out_port/out_vlan/out_len   frame header, held for the whole frame
//   rd_ptr          per-port read pointer, flattened port-major
//   proto_err       sticky: data returned while no header was outstanding
//   dbg_state       issue FSM state (IDLE=0, META_WAIT=1, ISSUE=2)
//
// Handshakes: meta_rd is a single-cycle pop with no back-pressure; the
// popped entry is on meta_rdata exactly two cycles after the pulse.
// fabric_ready only gates the start of a new frame, never a frame in flight.
// ram_rd_en is a request with no ready; every request is answered by exactly
// one fec_rd_valid cycle, in order.

module ingress_frame_reader #(
    parameter int NUM_PORTS      = 15,
    parameter int PORT_FIFO_SIZE = 'h4000,
    parameter int HDR_DEPTH      = 4,
    localparam int PTR_BITS      = $clog2(PORT_FIFO_SIZE),
    localparam int PORT_BITS     = $clog2(NUM_PORTS)
) (
    input  logic                            clk_ram_ctl,
    input  logic                            rst,
    input  logic [NUM_PORTS-1:0]            meta_empty,
    output logic [NUM_PORTS-1:0]            meta_rd,
    input  logic [NUM_PORTS*23-1:0]         meta_rdata,
    input  logic                            fabric_ready,
    output logic                            ram_rd_en,
    output logic [PORT_BITS+PTR_BITS-1:0]   ram_rd_addr,
    input  logic                            fec_rd_valid,
    input  logic [127:0]                    fec_rd_data,
    output logic                            out_valid,
    output logic                            out_start,
    output logic                            out_last,
    output logic [127:0]                    out_data,
    output logic [4:0]                      out_last_bytes,
    output logic [PORT_BITS-1:0]            out_port,
    output logic [11:0]                     out_vlan,
    output logic [10:0]                     out_len,
    output logic [NUM_PORTS*PTR_BITS-1:0]   rd_ptr,
    output logic                            proto_err,
    output logic [1:0]                      dbg_state
);

    localparam int HQ_BITS  = (HDR_DEPTH > 1) ? $clog2(HDR_DEPTH) : 1;
    localparam int CNT_BITS = $clog2(HDR_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        META_WAIT = 2'd1,
        ISSUE     = 2'd2
    } state_t;

    state_t state, state_next;

    logic [PORT_BITS-1:0] rr_port;
    logic [PORT_BITS-1:0] cur_port;
    logic [PORT_BITS-1:0] sel_port;
    logic                 sel_any;
    logic [1:0]           wait_cnt;
    logic [7:0]           issue_left;
    logic [PTR_BITS-1:0]  ptr_q [NUM_PORTS];

    logic pop_go;
    logic hdr_push;
    logic issue_go;

    // Metadata entry of the port being served.
    logic [22:0] meta_word;
    logic [10:0] meta_len;
    logic [11:0] meta_vlan;
    logic [7:0]  meta_words;

    // In-flight header queue.
    logic [PORT_BITS-1:0] hq_port [HDR_DEPTH];
    logic [11:0]          hq_vlan [HDR_DEPTH];
    logic [10:0]          hq_len  [HDR_DEPTH];
    logic [HQ_BITS-1:0]   hq_wr;
    logic [HQ_BITS-1:0]   hq_rd;
    logic [CNT_BITS-1:0]  hq_cnt;
    logic                 hq_full;
    logic                 hq_empty;
    logic                 hdr_pop;

    // Data side.
    logic [7:0]  out_cnt;
    logic [10:0] head_len;
    logic [7:0]  head_words;
    logic        data_take;
    logic        data_last;

    assign hq_full  = (hq_cnt == CNT_BITS'(HDR_DEPTH));
    assign hq_empty = (hq_cnt == '0);

    assign meta_word  = meta_rdata[int'(cur_port)*23 +: 23];
    assign meta_len   = meta_word[10:0];
    assign meta_vlan  = meta_word[22:11];
    assign meta_words = 8'((12'(meta_len) + 12'd15) >> 4);

    assign dbg_state = state;

    // Round-robin pick: rr_port wins if it has metadata, otherwise the
    // highest-numbered non-empty port (the ascending loop leaves the last hit).
    always_comb begin
        sel_any  = 1'b0;
        sel_port = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (!meta_empty[p]) begin
                sel_any  = 1'b1;
                sel_port = PORT_BITS'(p);
            end
        end
        if (!meta_empty[rr_port]) begin
            sel_port = rr_port;
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_ram_ctl or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop_go     = 1'b0;
        hdr_push   = 1'b0;
        issue_go   = 1'b0;
        case (state)
            IDLE: begin
                // The header-queue check covers the one frame that can be in
                // META_WAIT, since we only leave IDLE with a free slot.
                if (fabric_ready && !hq_full && sel_any) begin
                    pop_go     = 1'b1;
                    state_next = META_WAIT;
                end
            end
            META_WAIT: begin
                // wait_cnt==2 is the cycle in which meta_rdata is valid.
                if (wait_cnt == 2'd2) begin
                    if (meta_len != 11'd0) begin
                        hdr_push   = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            ISSUE: begin
                issue_go = 1'b1;
                if (issue_left == 8'd1) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign ram_rd_en   = issue_go;
    assign ram_rd_addr = issue_go ? {cur_port, ptr_q[cur_port]} : '0;

    // ------------------------------------------------------- issue datapath
    always_ff @(posedge clk_ram_ctl or posedge rst) begin
        if (rst) begin
            rr_port    <= '0;
            cur_port   <= '0;
            wait_cnt   <= '0;
            issue_left <= '0;
            meta_rd    <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                ptr_q[p] <= '0;
            end
        end else begin
            meta_rd <= '0;
            if (pop_go) begin
                meta_rd  <= NUM_PORTS'(1) << sel_port;
                cur_port <= sel_port;
                wait_cnt <= '0;
                rr_port  <= (rr_port == PORT_BITS'(NUM_PORTS - 1)) ? '0
                                                                   : rr_port + PORT_BITS'(1);
            end else if (state == META_WAIT) begin
                wait_cnt <= wait_cnt + 2'd1;
            end

            if (hdr_push) begin
                issue_left <= meta_words;
            end else if (issue_go) begin
                issue_left <= issue_left - 8'd1;
                ptr_q[cur_port] <= (ptr_q[cur_port] == PTR_BITS'(PORT_FIFO_SIZE - 1))
                                   ? '0 : ptr_q[cur_port] + PTR_BITS'(1);
            end
        end
    end

    always_comb begin
        rd_ptr = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rd_ptr[p*PTR_BITS +: PTR_BITS] = ptr_q[p];
        end
    end

    // --------------------------------------------------------- header queue
    assign head_len   = hq_len[hq_rd];
    assign head_words = 8'((12'(head_len) + 12'd15) >> 4);
    assign data_take  = fec_rd_valid && !hq_empty;
    assign data_last  = data_take && ((out_cnt + 8'd1) == head_words);
    assign hdr_pop    = data_last;

    always_ff @(posedge clk_ram_ctl or posedge rst) begin
        if (rst) begin
            hq_wr  <= '0;
            hq_rd  <= '0;
            hq_cnt <= '0;
            for (int i = 0; i < HDR_DEPTH; i++) begin
                hq_port[i] <= '0;
                hq_vlan[i] <= '0;
                hq_len[i]  <= '0;
            end
        end else begin
            if (hdr_push) begin
                hq_port[hq_wr] <= cur_port;
                hq_vlan[hq_wr] <= meta_vlan;
                hq_len[hq_wr]  <= meta_len;
                hq_wr <= (hq_wr == HQ_BITS'(HDR_DEPTH - 1)) ? '0 : hq_wr + HQ_BITS'(1);
            end
            if (hdr_pop) begin
                hq_rd <= (hq_rd == HQ_BITS'(HDR_DEPTH - 1)) ? '0 : hq_rd + HQ_BITS'(1);
            end
            case ({hdr_push, hdr_pop})
                2'b10:   hq_cnt <= hq_cnt + CNT_BITS'(1);
                2'b01:   hq_cnt <= hq_cnt - CNT_BITS'(1);
                default: hq_cnt <= hq_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------ data side
    always_ff @(posedge clk_ram_ctl or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_start      <= 1'b0;
            out_last       <= 1'b0;
            out_data       <= '0;
            out_last_bytes <= '0;
            out_port       <= '0;
            out_vlan       <= '0;
            out_len        <= '0;
            out_cnt        <= '0;
            proto_err      <= 1'b0;
        end else begin
            out_valid      <= data_take;
            out_start      <= data_take && (out_cnt == 8'd0);
            out_last       <= data_last;
            out_last_bytes <= !data_last ? 5'd0 :
                              (head_len[3:0] == 4'd0) ? 5'd16 : {1'b0, head_len[3:0]};
            if (data_take) begin
                out_data <= fec_rd_data;
                out_port <= hq_port[hq_rd];
                out_vlan <= hq_vlan[hq_rd];
                out_len  <= head_len;
                out_cnt  <= data_last ? 8'd0 : out_cnt + 8'd1;
            end
            // Words with no header to attach to are dropped.
            if (fec_rd_valid && hq_empty) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule
